// File: rtl/segre_pkg.sv
// Shared types for the segre memory arbiter: the queued request record, the
// requester id and the arbiter FSM states.
package segre_pkg;

    localparam int ARB_BUF_SIZE = 16;
    localparam int ARB_PTR_SIZE = $clog2(ARB_BUF_SIZE);
    localparam int ADDR_W       = 32;
    localparam int LINE_W       = 128;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } cache_id_e;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] cache_line;
        cache_id_e         cache_id;
    } cache_mem_req_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/segre_mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter. The slave modport is the
// arbiter's view; master is the view of the caches plus the memory model.
interface segre_mem_arbiter_if;
    import segre_pkg::*;

    logic              ic_req_i;
    logic [ADDR_W-1:0] ic_addr_i;
    logic              ic_ready_o;
    logic              dc_req_i;
    logic              dc_rd_i;
    logic              dc_wr_i;
    logic [ADDR_W-1:0] dc_addr_i;
    logic [LINE_W-1:0] dc_line_i;
    logic              dc_ready_o;
    logic              mem_req_o;
    logic              mem_rd_o;
    logic              mem_wr_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_line_o;
    logic              mem_ready_i;
    logic [LINE_W-1:0] mem_line_i;
    logic              ic_rsp_o;
    logic              dc_rsp_o;
    logic [LINE_W-1:0] rsp_line_o;

    // Handshakes: a cache push is taken on a clock edge where *_req_i and *_ready_o
    // are both 1; mem_req_o holds with stable fields until the edge where
    // mem_ready_i is 1; *_rsp_o is a single-cycle pulse that is never back-pressured.
    modport slave (
        input  ic_req_i, ic_addr_i, dc_req_i, dc_rd_i, dc_wr_i, dc_addr_i, dc_line_i,
               mem_ready_i, mem_line_i,
        output ic_ready_o, dc_ready_o, mem_req_o, mem_rd_o, mem_wr_o, mem_addr_o,
               mem_line_o, ic_rsp_o, dc_rsp_o, rsp_line_o
    );

    modport master (
        output ic_req_i, ic_addr_i, dc_req_i, dc_rd_i, dc_wr_i, dc_addr_i, dc_line_i,
               mem_ready_i, mem_line_i,
        input  ic_ready_o, dc_ready_o, mem_req_o, mem_rd_o, mem_wr_o, mem_addr_o,
               mem_line_o, ic_rsp_o, dc_rsp_o, rsp_line_o
    );

endinterface

// File: rtl/segre_arb_fifo.sv
// In-order request queue with up to two pushes and one pop per cycle.
// Slot b is only ever pushed together with slot a, so a pair lands contiguously.
module segre_arb_fifo
    import segre_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rsn,
    input  logic                  i_push_a,
    input  cache_mem_req_t        i_data_a,
    input  logic                  i_push_b,
    input  cache_mem_req_t        i_data_b,
    input  logic                  i_pop,
    output cache_mem_req_t        o_head,
    output logic [ARB_PTR_SIZE:0] o_count
);

    cache_mem_req_t          r_mem [ARB_BUF_SIZE];
    logic [ARB_PTR_SIZE-1:0] r_wr_ptr;
    logic [ARB_PTR_SIZE-1:0] r_rd_ptr;
    logic [ARB_PTR_SIZE:0]   r_count;
    logic [ARB_PTR_SIZE-1:0] w_wr_ptr_b;
    logic [ARB_PTR_SIZE:0]   w_n_push;
    logic [ARB_PTR_SIZE:0]   w_n_pop;

    assign w_wr_ptr_b = r_wr_ptr + ARB_PTR_SIZE'(1);
    assign w_n_push   = (ARB_PTR_SIZE+1)'(i_push_a) + (ARB_PTR_SIZE+1)'(i_push_b);
    assign w_n_pop    = (ARB_PTR_SIZE+1)'(i_pop);

    always_ff @(posedge i_clk) begin
        if (i_push_a) r_mem[r_wr_ptr] <= i_data_a;
        if (i_push_b) r_mem[w_wr_ptr_b] <= i_data_b;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_n_push[ARB_PTR_SIZE-1:0];
            if (i_pop) r_rd_ptr <= r_rd_ptr + ARB_PTR_SIZE'(1);
            r_count  <= r_count + w_n_push - w_n_pop;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/segre_mem_arbiter.sv
// Shares the main-memory port between icache and dcache through an in-order queue.
// Define SEGRE_ARB_RR_EN to alternate the enqueue order of same-cycle request pairs.
module segre_mem_arbiter
    import segre_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rsn_i,
    segre_mem_arbiter_if.slave    bus,
    output arb_state_e            o_dbg_state,
    output logic [ARB_PTR_SIZE:0] o_dbg_count
);

    localparam logic [ARB_PTR_SIZE:0] FULL_CNT = (ARB_PTR_SIZE+1)'(ARB_BUF_SIZE);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [LINE_W-1:0]     r_rsp_line;
    cache_id_e             r_rsp_id;
    logic [ARB_PTR_SIZE:0] w_count;
    logic [ARB_PTR_SIZE:0] w_free;
    logic                  w_ic_push;
    logic                  w_dc_push;
    logic                  w_ic_first;
    logic                  w_push_a;
    logic                  w_push_b;
    logic                  w_pop;
    logic                  w_mem_req;
    logic                  w_ic_rsp;
    logic                  w_dc_rsp;
    cache_mem_req_t        w_ic_entry;
    cache_mem_req_t        w_dc_entry;
    cache_mem_req_t        w_data_a;
    cache_mem_req_t        w_data_b;
    cache_mem_req_t        w_head;

    // Readiness looks only at the registered count; a pop frees space a cycle later.
    assign w_free         = FULL_CNT - w_count;
    assign bus.dc_ready_o = (w_free != '0);
    assign bus.ic_ready_o = (w_free >= (ARB_PTR_SIZE+1)'(2)) |
                            ((w_free == (ARB_PTR_SIZE+1)'(1)) & ~bus.dc_req_i);
    assign w_ic_push      = bus.ic_req_i & bus.ic_ready_o;
    assign w_dc_push      = bus.dc_req_i & bus.dc_ready_o;

    assign w_ic_entry = '{rd: 1'b1, wr: 1'b0, addr: bus.ic_addr_i, cache_line: '0, cache_id: ICACHE};
    assign w_dc_entry = '{rd: bus.dc_rd_i, wr: bus.dc_wr_i, addr: bus.dc_addr_i,
                          cache_line: bus.dc_line_i, cache_id: DCACHE};

`ifdef SEGRE_ARB_RR_EN
    cache_id_e r_rr_last;

    // r_rr_last names the requester that went first in the previous pair.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) r_rr_last <= ICACHE;
        else if (w_ic_push & w_dc_push) r_rr_last <= w_ic_first ? ICACHE : DCACHE;
    end

    assign w_ic_first = (r_rr_last == DCACHE);
`else
    assign w_ic_first = 1'b0;
`endif

    always_comb begin
        w_push_a = w_ic_push | w_dc_push;
        w_push_b = w_ic_push & w_dc_push;
        w_data_a = w_dc_entry;
        w_data_b = w_ic_entry;
        if ((w_ic_push & ~w_dc_push) | (w_push_b & w_ic_first)) begin
            w_data_a = w_ic_entry;
            w_data_b = w_dc_entry;
        end
    end

    segre_arb_fifo u_fifo (
        .i_clk    (clk_i),
        .i_rsn    (rsn_i),
        .i_push_a (w_push_a),
        .i_data_a (w_data_a),
        .i_push_b (w_push_b),
        .i_data_b (w_data_b),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_count  (w_count)
    );

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) r_state <= ARB_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_pop       = 1'b0;
        w_ic_rsp    = 1'b0;
        w_dc_rsp    = 1'b0;
        case (r_state)
            ARB_IDLE: if (w_count != '0) w_state_nxt = ARB_BUSY;
            ARB_BUSY: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready_i) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                w_ic_rsp    = (r_rsp_id == ICACHE);
                w_dc_rsp    = (r_rsp_id == DCACHE);
                w_state_nxt = (w_count != '0) ? ARB_BUSY : ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_rsp_line <= '0;
            r_rsp_id   <= ICACHE;
        end else if (w_pop) begin
            r_rsp_line <= bus.mem_line_i;
            r_rsp_id   <= w_head.cache_id;
        end
    end

    assign bus.mem_req_o  = w_mem_req;
    assign bus.mem_rd_o   = w_mem_req & w_head.rd;
    assign bus.mem_wr_o   = w_mem_req & w_head.wr;
    assign bus.mem_addr_o = w_mem_req ? w_head.addr : '0;
    assign bus.mem_line_o = w_mem_req ? w_head.cache_line : '0;
    assign bus.ic_rsp_o   = w_ic_rsp;
    assign bus.dc_rsp_o   = w_dc_rsp;
    assign bus.rsp_line_o = r_rsp_line;
    assign o_dbg_state    = r_state;
    assign o_dbg_count    = w_count;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Bench for segre_mem_arbiter: a queue-level reference model plus a simple memory
// responder, driven by a ready-boundary table, directed sequences and random traffic.
`timescale 1ns/1ps
module tb_segre_mem_arbiter;
  import segre_pkg::*;

  typedef struct packed {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] line;
    logic         is_dc;
  } req_t;

  typedef struct {
    bit ic;
    bit dc;
    bit exp_ic_rdy;
    bit exp_dc_rdy;
    int exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rsn = 1'b0;
  arb_state_e dbg_state;
  logic [ARB_PTR_SIZE:0] dbg_count;

  segre_mem_arbiter_if bus();

  segre_mem_arbiter dut (
    .clk_i       (clk),
    .rsn_i       (rsn),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_count (dbg_count)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  req_t exp_q[$];
  logic [31:0] issued_q[$];
  bit pend_rsp, pend_dc, pend_rd;
  logic [127:0] pend_line;
  bit prev_req, prev_hs;
  int stall;
  int n_pairs;
  int n_ic_rsp, n_dc_rsp;
  bit last_ic_rdy, last_dc_rdy, last_acc_ic, last_acc_dc;
  bit mem_block;
  int mem_age, mem_delay, mem_dmin, mem_dmax;
  int guard, sent;
  logic [31:0] exp_second_first;
  vec_t fill_tbl[11];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    pend_rsp = 1'b0;
    prev_req = 1'b0;
    prev_hs = 1'b0;
    stall = 0;
    n_pairs = 0;
    mem_age = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.ic_req_i = 1'b0;
    bus.dc_req_i = 1'b0;
  endtask

  task automatic drive(input bit ic, input logic [31:0] ic_addr, input bit dc, input bit dc_wr,
                       input logic [31:0] dc_addr, input logic [127:0] dc_line);
    bus.ic_req_i = ic;
    bus.ic_addr_i = ic_addr;
    bus.dc_req_i = dc;
    bus.dc_rd_i = ~dc_wr;
    bus.dc_wr_i = dc_wr;
    bus.dc_addr_i = dc_addr;
    bus.dc_line_i = dc_line;
  endtask

  task automatic drive_rand(input bit ic, input bit dc);
    drive(ic, $urandom & 32'hFFFF_FFF0, dc, 1'($urandom_range(0, 1)),
          $urandom & 32'hFFFF_FFF0, {$urandom, $urandom, $urandom, $urandom});
  endtask

  // One clock cycle: called at a negedge with cache inputs already set.
  task automatic step();
    int free;
    bit exp_ic, exp_dc, hs, ic_first;
    req_t ic_e, dc_e;
    bus.mem_ready_i = (!mem_block && bus.mem_req_o === 1'b1 && mem_age >= mem_delay);
    bus.mem_line_i = {$urandom, $urandom, $urandom, $urandom};
    #1;
    free = ARB_BUF_SIZE - exp_q.size();
    exp_dc = (free >= 1);
    exp_ic = (free >= 2) || (free == 1 && !bus.dc_req_i);
    last_ic_rdy = bus.ic_ready_o;
    last_dc_rdy = bus.dc_ready_o;
    check("dc_ready", bus.dc_ready_o, exp_dc);
    check("ic_ready", bus.ic_ready_o, exp_ic);
    check("count", dbg_count, exp_q.size());
    check("ic_rsp", bus.ic_rsp_o, pend_rsp && !pend_dc);
    check("dc_rsp", bus.dc_rsp_o, pend_rsp && pend_dc);
    if (pend_rsp && pend_rd) check("rsp_line", bus.rsp_line_o, pend_line);
    n_ic_rsp += int'(bus.ic_rsp_o);
    n_dc_rsp += int'(bus.dc_rsp_o);
    if (exp_q.size() == 0) check("mem_req_idle", bus.mem_req_o, 1'b0);
    if (prev_req && !prev_hs) check("mem_req_hold", bus.mem_req_o, 1'b1);
    if (bus.mem_req_o && exp_q.size() != 0) begin
      check("mem_rd", bus.mem_rd_o, exp_q[0].rd);
      check("mem_wr", bus.mem_wr_o, exp_q[0].wr);
      check("mem_addr", bus.mem_addr_o, exp_q[0].addr);
      if (exp_q[0].wr) check("mem_line", bus.mem_line_o, exp_q[0].line);
    end
    if (!bus.mem_req_o)
      check("mem_quiet", bus.mem_rd_o | bus.mem_wr_o | (|bus.mem_addr_o) | (|bus.mem_line_o), 1'b0);
    if (exp_q.size() != 0 && !bus.mem_req_o) stall++;
    else stall = 0;
    if (stall >= 3) check("mem_stall", bus.mem_req_o, 1'b1);

    // model update for the coming edge: pop the serviced head, then append pushes
    hs = bus.mem_req_o && bus.mem_ready_i;
    pend_rsp = 1'b0;
    if (hs && exp_q.size() != 0) begin
      pend_rsp = 1'b1;
      pend_dc = exp_q[0].is_dc;
      pend_rd = exp_q[0].rd;
      pend_line = bus.mem_line_i;
      issued_q.push_back(exp_q[0].addr);
      void'(exp_q.pop_front());
    end
    ic_e = '{rd: 1'b1, wr: 1'b0, addr: bus.ic_addr_i, line: '0, is_dc: 1'b0};
    dc_e = '{rd: bus.dc_rd_i, wr: bus.dc_wr_i, addr: bus.dc_addr_i, line: bus.dc_line_i, is_dc: 1'b1};
    last_acc_ic = bus.ic_req_i && exp_ic;
    last_acc_dc = bus.dc_req_i && exp_dc;
    ic_first = 1'b0;
`ifdef SEGRE_ARB_RR_EN
    if (last_acc_ic && last_acc_dc) begin
      ic_first = n_pairs[0];
      n_pairs++;
    end
`endif
    if (ic_first) begin
      exp_q.push_back(ic_e);
      exp_q.push_back(dc_e);
    end else begin
      if (last_acc_dc) exp_q.push_back(dc_e);
      if (last_acc_ic) exp_q.push_back(ic_e);
    end
    if (hs) begin
      mem_age = 0;
      mem_delay = $urandom_range(mem_dmax, mem_dmin);
    end else if (bus.mem_req_o) mem_age++;
    else mem_age = 0;
    prev_req = bus.mem_req_o;
    prev_hs = hs;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int g;
    g = 0;
    idle_inputs();
    while ((exp_q.size() != 0 || pend_rsp) && g < 600) begin
      step();
      g++;
    end
    check("drain_done", exp_q.size(), 0);
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 7; i++) fill_tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 2 * (i + 1)};
    fill_tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 15};
    fill_tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16};
    fill_tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16};
    fill_tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 16};

    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    bus.mem_ready_i = 1'b0;
    bus.mem_line_i = '0;
    mem_block = 1'b0;
    mem_dmin = 0;
    mem_dmax = 3;
    mem_delay = 0;
    clear_model();

    // reset state
    rsn = 1'b0;
    @(negedge clk);
    #1;
    check("rst_state", dbg_state, ARB_IDLE);
    check("rst_count", dbg_count, 0);
    check("rst_mem_req", bus.mem_req_o, 1'b0);
    check("rst_ic_rsp", bus.ic_rsp_o, 1'b0);
    check("rst_dc_rsp", bus.dc_rsp_o, 1'b0);
    check("rst_rsp_line", bus.rsp_line_o, 0);
    check("rst_ic_ready", bus.ic_ready_o, 1'b1);
    check("rst_dc_ready", bus.dc_ready_o, 1'b1);
    rsn = 1'b1;
    @(negedge clk);

    // single icache read, memory answers after 3 waiting cycles
    mem_dmin = 3;
    mem_dmax = 3;
    mem_delay = 3;
    n_ic_rsp = 0;
    n_dc_rsp = 0;
    drive(1'b1, 32'h100, 1'b0, 1'b0, '0, '0);
    step();
    idle_inputs();
    check("lat_first_cycle", bus.mem_req_o, 1'b0);
    step();
    check("lat_second_cycle", bus.mem_req_o, 1'b1);
    check("lat_addr", bus.mem_addr_o, 32'h100);
    drain();
    check("single_ic_rsp_n", n_ic_rsp, 1);
    check("single_dc_rsp_n", n_dc_rsp, 0);

    // simultaneous pushes from idle
    mem_dmin = 0;
    mem_dmax = 2;
    issued_q.delete();
    drive(1'b1, 32'h300, 1'b1, 1'b1, 32'h200, {4{32'hA5A5_5A5A}});
    step();
    idle_inputs();
    drain();
    drive(1'b1, 32'h340, 1'b1, 1'b1, 32'h240, {4{32'h1234_5678}});
    step();
    idle_inputs();
    drain();
`ifdef SEGRE_ARB_RR_EN
    exp_second_first = 32'h340;
`else
    exp_second_first = 32'h240;
`endif
    check("pair_issued_n", issued_q.size(), 4);
    check("pair1_first", issued_q[0], 32'h200);
    check("pair1_second", issued_q[1], 32'h300);
    check("pair2_first", issued_q[2], exp_second_first);

    // fill with memory stalled: ready boundaries from the table
    mem_block = 1'b1;
    foreach (fill_tbl[i]) begin
      drive_rand(fill_tbl[i].ic, fill_tbl[i].dc);
      step();
      check($sformatf("tbl%0d_ic_ready", i), last_ic_rdy, fill_tbl[i].exp_ic_rdy);
      check($sformatf("tbl%0d_dc_ready", i), last_dc_rdy, fill_tbl[i].exp_dc_rdy);
      check($sformatf("tbl%0d_count", i), dbg_count, fill_tbl[i].exp_cnt);
    end
    idle_inputs();
    mem_block = 1'b0;
    mem_delay = 0;
    step();
    mem_block = 1'b1;
    drive_rand(1'b1, 1'b0);
    step();
    check("after_pop_dc_ready", last_dc_rdy, 1'b1);
    check("after_pop_ic_ready", last_ic_rdy, 1'b1);
    check("after_pop_count", dbg_count, 16);
    mem_block = 1'b0;
    mem_dmin = 0;
    mem_dmax = 3;
    drain();

    // 40 alternating requests through the wrapping queue
    n_ic_rsp = 0;
    n_dc_rsp = 0;
    mem_dmin = 0;
    mem_dmax = 5;
    sent = 0;
    guard = 0;
    while (sent < 40 && guard < 3000) begin
      if ($urandom_range(0, 3) == 0) idle_inputs();
      else drive_rand(sent % 2 == 0, sent % 2 == 1);
      step();
      sent += int'(last_acc_ic) + int'(last_acc_dc);
      guard++;
    end
    check("wrap_all_sent", sent, 40);
    drain();
    check("wrap_ic_rsp_n", n_ic_rsp, 20);
    check("wrap_dc_rsp_n", n_dc_rsp, 20);

    // random mixed traffic
    mem_dmax = 6;
    for (int i = 0; i < 300; i++) begin
      drive_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step();
    end
    drain();

    // asynchronous reset while a memory handshake is pending
    mem_block = 1'b1;
    guard = 0;
    do begin
      drive_rand(1'b1, 1'b1);
      step();
      guard++;
    end while (!bus.mem_req_o && guard < 50);
    check("rst_reach_busy", bus.mem_req_o, 1'b1);
    bus.mem_ready_i = 1'b1;
    #2;
    rsn = 1'b0;
    #1;
    check("arst_mem_req", bus.mem_req_o, 1'b0);
    check("arst_count", dbg_count, 0);
    check("arst_state", dbg_state, ARB_IDLE);
    idle_inputs();
    bus.mem_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear_model();
    n_ic_rsp = 0;
    n_dc_rsp = 0;
    rsn = 1'b1;
    repeat (5) step();
    check("arst_no_rsp", n_ic_rsp + n_dc_rsp, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
